// File: rtl/dm_access_if.sv
// Memory-side port of the data-memory access controller.
// The controller drives address, strobes and write data; the memory array
// answers with read data and a completion flag.
interface dm_access_if;
    logic [15:0] dm_mem_add;
    logic        dm_mem_rd_en;
    logic        dm_mem_wr_en;
    logic [15:0] dm_mem_wdt;
    logic [15:0] mem_dm_rdt;
    logic        mem_dm_rdy;

    modport master (
        output dm_mem_add,
        output dm_mem_rd_en,
        output dm_mem_wr_en,
        output dm_mem_wdt,
        input  mem_dm_rdt,
        input  mem_dm_rdy
    );

    modport slave (
        input  dm_mem_add,
        input  dm_mem_rd_en,
        input  dm_mem_wr_en,
        input  dm_mem_wdt,
        output mem_dm_rdt,
        output mem_dm_rdy
    );
endinterface

// File: rtl/dm_access.sv
// Data-memory access controller: captures a DAG address, direction and write
// data, runs one outstanding access against a wait-state memory port, returns
// read data to the bus, stalls the sequencer while pending and aborts accesses
// that exceed TMO_CYC cycles.
// Optional feature: define DM_BOUNDS_CHK_EN to reject addresses >= DM_DEPTH
// at accept time (no strobe, sticky error, zero read data returned).
module dm_access #(
    parameter int          TMO_CYC  = 16,
    parameter logic [15:0] DM_DEPTH = 16'h4000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ps_dm_en,
    input  logic               ps_dm_wrt,
    input  logic               ps_dm_err_clr,
    input  logic [15:0]        dg_dm_add,
    input  logic [15:0]        bc_dt,
    dm_access_if.master        mem,
    output logic [15:0]        dm_bc_dt,
    output logic               dm_bc_vld,
    output logic               dm_ps_stall,
    output logic               dm_err
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Last wait-counter value before an access is abandoned.
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t     state;
    logic       dir_wrt;
    logic [7:0] wait_cnt;
    logic       out_of_range;
    logic       timeout_hit;
    logic       bounds_hit;

`ifdef DM_BOUNDS_CHK_EN
    // Addresses past the implemented array are refused before any strobe.
    assign out_of_range = (dg_dm_add >= DM_DEPTH);
`else
    // Every address goes to memory; DM_DEPTH only feeds a dangling net.
    logic unused_depth;
    assign unused_depth = ^DM_DEPTH;
    assign out_of_range = 1'b0;
`endif

    // Error sources and the sequencer stall.
    always_comb begin
        timeout_hit = (state == ACC) && !mem.mem_dm_rdy && (wait_cnt == TMO_LAST);
        bounds_hit  = (state == IDLE) && ps_dm_en && out_of_range;
        dm_ps_stall = (state == ACC) && !mem.mem_dm_rdy;
    end

    // Access FSM with registered strobes, address, write data and read return.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            dir_wrt          <= 1'b0;
            wait_cnt         <= 8'd0;
            mem.dm_mem_add   <= 16'h0000;
            mem.dm_mem_wdt   <= 16'h0000;
            mem.dm_mem_rd_en <= 1'b0;
            mem.dm_mem_wr_en <= 1'b0;
            dm_bc_dt         <= 16'h0000;
            dm_bc_vld        <= 1'b0;
        end else begin
            dm_bc_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (ps_dm_en) begin
                        if (out_of_range) begin
                            if (!ps_dm_wrt) begin
                                dm_bc_dt  <= 16'h0000;
                                dm_bc_vld <= 1'b1;
                            end
                        end else begin
                            state            <= ACC;
                            dir_wrt          <= ps_dm_wrt;
                            wait_cnt         <= 8'd0;
                            mem.dm_mem_add   <= dg_dm_add;
                            mem.dm_mem_wdt   <= bc_dt;
                            mem.dm_mem_rd_en <= !ps_dm_wrt;
                            mem.dm_mem_wr_en <= ps_dm_wrt;
                        end
                    end
                end
                ACC: begin
                    if (mem.mem_dm_rdy) begin
                        state            <= IDLE;
                        mem.dm_mem_rd_en <= 1'b0;
                        mem.dm_mem_wr_en <= 1'b0;
                        if (!dir_wrt) begin
                            dm_bc_dt  <= mem.mem_dm_rdt;
                            dm_bc_vld <= 1'b1;
                        end
                    end else if (wait_cnt == TMO_LAST) begin
                        state            <= IDLE;
                        mem.dm_mem_rd_en <= 1'b0;
                        mem.dm_mem_wr_en <= 1'b0;
                        if (!dir_wrt) begin
                            dm_bc_dt  <= 16'h0000;
                            dm_bc_vld <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error: a new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dm_err <= 1'b0;
        end else if (timeout_hit || bounds_hit) begin
            dm_err <= 1'b1;
        end else if (ps_dm_err_clr) begin
            dm_err <= 1'b0;
        end
    end

endmodule

// File: doc/dm_access.md
# dm_access

Data-memory access controller between the data address generator and the data-memory array. It captures the DAG's data-memory address, the access direction and the write data from the bus, then runs a single outstanding access against a memory port that may insert wait states. It returns read data to the bus, stalls the program sequencer while the access is pending, and aborts accesses that time out.

## Interface
Parameters:
- TMO_CYC, 16: maximum cycles in ACC before an access is aborted; legal range 2–255.
- DM_DEPTH, 16'h4000: number of implemented memory words. Used only when DM_BOUNDS_CHK_EN is defined.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- ps_dm_en  in  1  access request from the sequencer; sampled only in IDLE.
- ps_dm_wrt  in  1  1 = write, 0 = read.
- ps_dm_err_clr  in  1  clears dm_err.
- dg_dm_add  in  16  data-memory address from the DAG.
- bc_dt  in  16  write data from the bus.
- dm_mem_add  out  16  memory address.
- dm_mem_rd_en  out  1  memory read strobe.
- dm_mem_wr_en  out  1  memory write strobe.
- dm_mem_wdt  out  16  memory write data.
- mem_dm_rdt  in  16  memory read data; valid when mem_dm_rdy=1.
- mem_dm_rdy  in  1  memory completion for the current strobe.
- dm_bc_dt  out  16  read data to the bus.
- dm_bc_vld  out  1  one-cycle pulse: dm_bc_dt is valid (reads only).
- dm_ps_stall  out  1  combinational stall to the sequencer.
- dm_err  out  1  sticky error flag (timeout or bounds violation).

## Operation
- States: IDLE, ACC.
- IDLE with ps_dm_en=1 (accept):
  - Register dg_dm_add into dm_mem_add.
  - Register bc_dt into dm_mem_wdt.
  - Register ps_dm_wrt as the direction.
  - Clear the wait counter and go to ACC.
- IDLE with ps_dm_en=0: hold state; strobes stay 0.
- In ACC:
  - Exactly one of dm_mem_rd_en/dm_mem_wr_en is 1, chosen by the registered direction.
  - Address and write data are held stable.
- ACC with mem_dm_rdy=1:
  - Go to IDLE.
  - For a read, register mem_dm_rdt into dm_bc_dt and pulse dm_bc_vld in the next cycle.
  - For a write, dm_bc_vld stays 0.
- ACC with mem_dm_rdy=0: increment the 8-bit wait counter.
- Timeout: counter == TMO_CYC-1 with mem_dm_rdy=0:
  - Abort: go to IDLE and set dm_err.
  - For a read, dm_bc_dt=16'h0000 and dm_bc_vld pulses next cycle.
- dm_ps_stall = (state==ACC) & ~mem_dm_rdy. It is 0 in IDLE.
- While ACC, ps_dm_en is ignored. No queuing: the sequencer holds its request under stall.
- dm_bc_dt holds its last value between pulses.
- dm_err:
  - Set on a timeout or bounds violation.
  - Cleared by ps_dm_err_clr. A set and a clear in the same cycle leave dm_err set.

## Timing
- Reset (rst=0 at an edge) takes priority over every other event, including mid-access. Values after reset:
  - state IDLE; wait counter 0.
  - dm_mem_add, dm_mem_wdt, dm_bc_dt = 16'h0000.
  - dm_mem_rd_en, dm_mem_wr_en, dm_bc_vld, dm_err = 0.
  - dm_ps_stall = 0.
- Request sampled at edge N. Strobes are high from cycle N+1.
- With rdy=1 in cycle N+1, the read data is on dm_bc_dt with dm_bc_vld=1 in cycle N+2.
- Each wait cycle adds one cycle of latency.
- Minimum spacing is 2 cycles per access: the next request is accepted at the edge ending the dm_bc_vld cycle.
- Strobes deassert in the cycle after rdy or timeout.
- A timeout leaves the strobes high for exactly TMO_CYC cycles.

## Configuration
- DM_BOUNDS_CHK_EN defined:
  - At accept, dg_dm_add >= DM_DEPTH means no strobe is issued and the FSM stays in IDLE.
  - dm_err is set in the next cycle.
  - For a read, dm_bc_vld pulses in the next cycle with dm_bc_dt=16'h0000.
  - dm_ps_stall stays 0.
- DM_BOUNDS_CHK_EN undefined:
  - All 16-bit addresses are passed to memory.
  - DM_DEPTH is ignored, and no logic is generated for it.

## Test plan
- Zero-wait read: rdy tied 1, read dg_dm_add=16'h0012 with mem_dm_rdt=16'hBEEF -> rd_en high for 1 cycle; dm_bc_dt=16'hBEEF, dm_bc_vld=1 at N+2; stall never high.
- Write with 3 wait states: write 16'h00A5 to 16'h0100, rdy high on the 4th ACC cycle -> wr_en high 4 cycles with add/wdt stable; stall high 3 cycles; no dm_bc_vld.
- Timeout, TMO_CYC=16, rdy held 0 on a read -> rd_en high 16 cycles; dm_bc_dt=0, dm_bc_vld=1, dm_err=1; ps_dm_err_clr pulse -> dm_err=0.
- Back-to-back reads at 16'h0001 and 16'h0002, rdy=1 -> accepts at N and N+2; two dm_bc_vld pulses at N+2 and N+4 with the correct data.
- rst=0 while ACC with 2 waits elapsed -> next cycle all outputs at reset values; rst=1 with ps_dm_en=1 -> a new access starts normally.
- DM_BOUNDS_CHK_EN, DM_DEPTH=16'h4000, read 16'h4000 -> no strobe; dm_err=1, dm_bc_vld=1 with 16'h0000; read 16'h3FFF -> normal access.
